ternary_neuron_accum: RTL and testbench

TERNARY_NEURON_ACCUM -- requirements
Module: ternary_neuron_accum

---
 rtl/ternary_neuron_accum.sv | 123 ++++++++++++
 tb/tb_ternary_neuron_accum.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ternary_neuron_accum.sv
// ternary_neuron_accum
//   Accumulates (pc_pos - pc_neg) popcount differences over up to MAX_BEATS
//   beats into a saturating signed sum. When the neuron completes, the sum is
//   thresholded into a ternary activation and held until downstream takes it.
//
// Ports
//   clk, rst_n        : clock (rising edge), async active-low reset
//   pc_pos, pc_neg    : 5-bit unsigned popcounts of +1 / -1 weight matches
//   in_valid/in_ready : beat handshake; in_last marks the neuron's final beat
//   thr_hi, thr_lo    : signed thresholds, sampled on the final beat
//   out_valid/out_ready : result handshake
//   out_act           : 01 = +1, 11 = -1, 00 = 0 (00 whenever out_valid = 0)
//   out_sum           : saturated final sum
//   out_err           : neuron cut off at MAX_BEATS without in_last
module ternary_neuron_accum #(
  parameter int ACC_W     = 10,
  parameter int MAX_BEATS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4:0]              pc_pos,
  input  logic [4:0]              pc_neg,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_err
);

  // Two guard bits: one for the popcount difference, one for the carry of
  // acc + diff, so the pre-saturation sum never wraps.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] SMAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {3'b111, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q, out_sum_q, thr_hi_q, thr_lo_q;
  logic [4:0]              cnt_q;
  logic                    out_valid_q, out_err_q;

  logic                    accept, final_beat;
  logic [4:0]              cnt_d;
  logic signed [SW-1:0]    base, delta, raw;
  logic signed [ACC_W-1:0] acc_d;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    // A beat taken in IDLE starts a fresh sum.
    base  = (state_q == IDLE) ? '0 : {{2{acc_q[ACC_W-1]}}, acc_q};
    // Popcounts are unsigned: zero-extend before subtracting.
    delta = $signed({{(SW-5){1'b0}}, pc_pos}) - $signed({{(SW-5){1'b0}}, pc_neg});
    raw   = base + delta;
    if (raw > SMAX)      acc_d = SMAX[ACC_W-1:0];
    else if (raw < SMIN) acc_d = SMIN[ACC_W-1:0];
    else                 acc_d = raw[ACC_W-1:0];
    cnt_d      = (state_q == IDLE) ? 5'd1 : cnt_q + 5'd1;
    final_beat = in_last || (cnt_d == 5'(MAX_BEATS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      thr_hi_q    <= '0;
      thr_lo_q    <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (final_beat) begin
              state_q     <= HOLD;
              out_sum_q   <= acc_d;
              thr_hi_q    <= thr_hi;
              thr_lo_q    <= thr_lo;
              // A final beat without in_last can only be the MAX_BEATS cutoff.
              out_err_q   <= !in_last;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // +1 is tested first so overlapping thresholds resolve to +1.
  always_comb begin
    out_act = 2'b00;
    if (out_valid_q) begin
      if (out_sum_q >= thr_hi_q)      out_act = 2'b01;
      else if (out_sum_q <= thr_lo_q) out_act = 2'b11;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ternary_neuron_accum.sv
module tb_ternary_neuron_accum;
  localparam int ACC_W = 9;
  localparam int MAXB  = 16;
  localparam int SMAX  = 255;
  localparam int SMIN  = -256;

  logic clk = 0, rst_n = 0;
  logic [4:0] pc_pos = 0, pc_neg = 0;
  logic in_valid = 0, in_last = 0, in_ready;
  logic signed [ACC_W-1:0] thr_hi = 0, thr_lo = 0;
  logic out_valid, out_ready = 0, out_err;
  logic [1:0] out_act;
  logic signed [ACC_W-1:0] out_sum;

  int checks = 0, errors = 0;

  ternary_neuron_accum #(.ACC_W(ACC_W), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .pc_pos(pc_pos), .pc_neg(pc_neg),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .out_valid(out_valid),
    .out_ready(out_ready), .out_act(out_act), .out_sum(out_sum),
    .out_err(out_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: running integer sum, beat count, pending result.
  bit m_hold = 0;
  int m_cnt = 0, m_sum = 0, m_res = 0, m_hi = 0, m_lo = 0;
  bit m_err = 0;

  function automatic int act_of(input int s, input int hi, input int lo);
    if (s >= hi) return 1;
    if (s <= lo) return 3;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hold = 0; m_cnt = 0; m_sum = 0; m_res = 0; m_hi = 0; m_lo = 0; m_err = 0;
    end else if (m_hold) begin
      if (out_ready) begin m_hold = 0; m_cnt = 0; end
    end else if (in_valid) begin
      if (m_cnt == 0) m_sum = 0;
      m_sum = m_sum + int'(pc_pos) - int'(pc_neg);
      if (m_sum > SMAX) m_sum = SMAX;
      if (m_sum < SMIN) m_sum = SMIN;
      m_cnt++;
      if (in_last || m_cnt == MAXB) begin
        m_hold = 1; m_res = m_sum; m_err = !in_last;
        m_hi = int'(thr_hi); m_lo = int'(thr_lo);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_hold));
    chk("out_valid", int'(out_valid), int'(m_hold));
    if (m_hold) begin
      chk("out_sum", int'(out_sum), m_res);
      chk("out_err", int'(out_err), int'(m_err));
      chk("out_act", int'(out_act), act_of(m_res, m_hi, m_lo));
    end else begin
      chk("out_act_idle", int'(out_act), 0);
    end
  end

  task automatic beat(input int p, input int n, input bit l);
    pc_pos = 5'(p); pc_neg = 5'(n); in_last = l; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("hs_valid_clear", int'(out_valid), 0);
  endtask

  initial begin
    #2;
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_act", int'(out_act), 0);
    chk("rst_err", int'(out_err), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Scenario 1
    thr_hi = 40; thr_lo = -5;
    beat(20, 3, 0); beat(10, 12, 0);
    chk("s1_not_yet", int'(out_valid), 0);
    beat(31, 0, 1);
    chk("s1_valid", int'(out_valid), 1);
    chk("s1_sum", int'(out_sum), 46);
    chk("s1_model", m_res, 46);
    chk("s1_act", int'(out_act), 1);
    chk("s1_err", int'(out_err), 0);
    handshake();

    // Scenario 2
    thr_hi = 0; thr_lo = -10;
    beat(0, 31, 1);
    chk("s2_sum", int'(out_sum), -31);
    chk("s2_act", int'(out_act), 3);
    handshake();

    // Scenario 3: saturation and MAX_BEATS cutoff
    thr_hi = 100; thr_lo = -100;
    for (int i = 0; i < MAXB; i++) begin
      chk("s3_ready_accum", int'(in_ready), 1);
      beat(31, 0, 0);
    end
    chk("s3_valid", int'(out_valid), 1);
    chk("s3_sum", int'(out_sum), 255);
    chk("s3_model", m_res, 255);
    chk("s3_err", int'(out_err), 1);
    chk("s3_ready", int'(in_ready), 0);
    chk("s3_act", int'(out_act), 1);
    handshake();

    // Scenario 4: backpressure
    thr_hi = 5; thr_lo = -5;
    beat(3, 1, 1);
    pc_pos = 9; pc_neg = 0; in_last = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("s4_hold_sum", int'(out_sum), 2);
      chk("s4_hold_act", int'(out_act), 0);
      chk("s4_hold_ready", int'(in_ready), 0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("s4_idle_valid", int'(out_valid), 0);
    chk("s4_idle_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    chk("s4_next_valid", int'(out_valid), 1);
    chk("s4_next_sum", int'(out_sum), 9);
    handshake();

    // Scenario 5: threshold edges
    thr_hi = 5; thr_lo = 5;
    beat(5, 0, 1);
    chk("s5_eq_act", int'(out_act), 1);
    handshake();
    beat(4, 0, 1);
    chk("s5_lo_act", int'(out_act), 3);
    handshake();
    thr_hi = 10; thr_lo = 0;
    beat(3, 0, 1);
    chk("s5_zero_act", int'(out_act), 0);
    handshake();

    // Scenario 6: reset mid-accumulation
    beat(1, 0, 0); beat(1, 0, 0);
    #1 rst_n = 0;
    #1;
    chk("s6_sum", int'(out_sum), 0);
    chk("s6_valid", int'(out_valid), 0);
    chk("s6_act", int'(out_act), 0);
    chk("s6_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1;
    beat(7, 2, 1);
    chk("s6_sum_after", int'(out_sum), 5);
    chk("s6_valid_after", int'(out_valid), 1);
    handshake();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
